// File: rtl/tlul_mem_arbiter.sv
// N-host to 1-device TL-UL arbiter for the shared main-memory port.
// A channel: round-robin with a grant lock that holds a presented request
// until the device accepts it. D channel: responses return in request order,
// so a FIFO of granted host indices steers each response to its originator.

package tlul_pkg;
   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

// Per-host response view: D fields only when this host owns the FIFO head,
// a_ready only when this host holds the grant.
module tlul_mem_arbiter_host
   import tlul_pkg::*;
(
   input  logic    a_gnt,
   input  logic    d_sel,
   input  tl_d2h_t rsp,
   output tl_d2h_t host_rsp
);
   // steer the device response or present an idle D channel
   always_comb begin
      host_rsp = '0;
      if (d_sel) host_rsp = rsp;
      host_rsp.a_ready = a_gnt;
   end
endmodule

module tlul_mem_arbiter
   import tlul_pkg::*;
#(
   parameter int NumHosts       = 3,
   parameter int MaxOutstanding = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  tl_h2d_t [NumHosts-1:0]              tl_h_i,
   output tl_d2h_t [NumHosts-1:0]              tl_h_o,
   output tl_h2d_t                             tl_d_o,
   input  tl_d2h_t                             tl_d_i,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
   output logic                                err_unexp_rsp_o
);
   localparam int IW = $clog2(NumHosts);
   localparam int PW = $clog2(MaxOutstanding);
   localparam int CW = $clog2(MaxOutstanding+1);

   logic [IW-1:0]                      rr_q, lock_idx_q, winner, head;
   logic                               lock_q, err_q;
   logic [MaxOutstanding-1:0][IW-1:0]  fifo_q;
   logic [PW-1:0]                      wptr_q, rptr_q;
   logic [CW-1:0]                      cnt_q;
   logic                               fifo_full, fifo_empty;
   logic                               a_gnt, a_hs, d_hs, push, pop, unexp;

   assign fifo_full  = (cnt_q == CW'(MaxOutstanding));
   assign fifo_empty = (cnt_q == '0);
   assign head       = fifo_q[rptr_q];

   // winner: locked host, else first requester at or after rr pointer
   always_comb begin
      logic          found;
      logic [IW-1:0] idx;
      winner = rr_q;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NumHosts; k++) begin
         idx = IW'((int'(rr_q) + k) % NumHosts);
         if (!found && tl_h_i[idx].a_valid) begin
            winner = idx;
            found  = 1'b1;
         end
      end
      if (lock_q) winner = lock_idx_q;
   end

   // device request: winner's A fields verbatim; D ready follows head host
   always_comb begin
      tl_d_o         = tl_h_i[winner];
      tl_d_o.a_valid = rst_ni & tl_h_i[winner].a_valid & ~fifo_full;
      tl_d_o.d_ready = fifo_empty ? 1'b1 : tl_h_i[head].d_ready;
   end

   assign a_gnt = rst_ni & tl_d_i.a_ready & ~fifo_full;
   assign a_hs  = tl_d_o.a_valid & tl_d_i.a_ready;
   assign d_hs  = tl_d_i.d_valid & tl_d_o.d_ready;
   assign push  = a_hs;
   assign pop   = d_hs & ~fifo_empty;
   assign unexp = tl_d_i.d_valid & fifo_empty;

   for (genvar g = 0; g < NumHosts; g++) begin : g_host
      tlul_mem_arbiter_host u_host (
         .a_gnt    (a_gnt && (winner == IW'(g))),
         .d_sel    (!fifo_empty && (head == IW'(g))),
         .rsp      (tl_d_i),
         .host_rsp (tl_h_o[g])
      );
   end

   // arbitration state: rr pointer advances past an accepted host, lock holds
   // a presented-but-stalled request until its handshake
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (a_hs) begin
         rr_q   <= (winner == IW'(NumHosts-1)) ? '0 : winner + 1'b1;
         lock_q <= 1'b0;
      end else if (tl_d_o.a_valid) begin
         lock_q     <= 1'b1;
         lock_idx_q <= winner;
      end
   end

   // routing FIFO of host indices plus count and sticky error flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_q <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push) begin
            fifo_q[wptr_q] <= winner;
            wptr_q         <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (unexp) err_q <= 1'b1;
      end
   end

   assign outstanding_o   = cnt_q;
   assign err_unexp_rsp_o = err_q;
endmodule

// File: tb/tb_tlul_mem_arbiter.sv
// Randomized bench for tlul_mem_arbiter: host and device models drive
// traffic; a negedge monitor predicts grants/routing and scoreboards responses.
module tb_tlul_mem_arbiter;
   import tlul_pkg::*;
   localparam int N  = 3;
   localparam int MO = 4;
   localparam int CW = $clog2(MO+1);
   localparam logic [31:0] DKEY = 32'h5EAD_BEEF; // device read data = addr ^ DKEY

   logic                clk = 1'b0;
   logic                rst_ni = 1'b0;
   tl_h2d_t [N-1:0]     tl_h_i;
   tl_d2h_t [N-1:0]     tl_h_o;
   tl_h2d_t             tl_d_o;
   tl_d2h_t             tl_d_i;
   logic [CW-1:0]       outstanding_o;
   logic                err_unexp_rsp_o;

   tlul_mem_arbiter #(.NumHosts(N), .MaxOutstanding(MO)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .tl_h_i          (tl_h_i),
      .tl_h_o          (tl_h_o),
      .tl_d_o          (tl_d_o),
      .tl_d_i          (tl_d_i),
      .outstanding_o   (outstanding_o),
      .err_unexp_rsp_o (err_unexp_rsp_o)
   );

   always #5 clk = ~clk;

   typedef struct { int host; logic [31:0] data; logic [7:0] source; } exp_t;
   typedef struct { logic [31:0] addr; logic [7:0] source; } dev_t;
   exp_t sb[$];
   dev_t dev_q[$];

   int n_vec = 0, n_err = 0;
   // reference model state
   int last_gnt = N-1, cnt = 0, pend_host = 0;
   bit pend = 0, exp_err = 0;
   logic [31:0] pend_addr;
   // handshake flags from monitor to stimulus
   bit hs_host[N];
   bit dev_dhs;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      int  w, h;
      bit  any, full, eav, dr;
      for (int i = 0; i < N; i++) hs_host[i] = 0;
      dev_dhs = 0;
      if (!rst_ni) begin
         chk("rst_outstanding", outstanding_o, 0);
         chk("rst_err", err_unexp_rsp_o, 0);
         chk("rst_a_valid", tl_d_o.a_valid, 0);
         for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_a_ready%0d", i), tl_h_o[i].a_ready, 0);
            chk($sformatf("rst_d_valid%0d", i), tl_h_o[i].d_valid, 0);
         end
         last_gnt = N-1; cnt = 0; pend = 0; exp_err = 0;
         sb.delete();
      end else begin
         chk("outstanding", outstanding_o, cnt);
         chk("err_unexp", err_unexp_rsp_o, exp_err);
         full = (cnt == MO);
         any = 0; w = 0;
         if (pend) begin
            any = 1; w = pend_host;
         end else begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (last_gnt + k) % N;
               if (!any && tl_h_i[c].a_valid) begin any = 1; w = c; end
            end
         end
         eav = any && !full;
         chk("a_valid", tl_d_o.a_valid, eav);
         if (eav) begin
            chk("a_address", tl_d_o.a_address, tl_h_i[w].a_address);
            chk("a_source", tl_d_o.a_source, tl_h_i[w].a_source);
            if (pend) chk("lock_stable", tl_d_o.a_address, pend_addr);
         end
         for (int i = 0; i < N; i++)
            if (tl_h_i[i].a_valid)
               chk($sformatf("a_ready%0d", i), tl_h_o[i].a_ready,
                   (any && i == w && tl_d_i.a_ready && !full));
         // D channel
         dr = 1; h = -1;
         if (sb.size() > 0) begin h = sb[0].host; dr = tl_h_i[h].d_ready; end
         chk("d_ready", tl_d_o.d_ready, dr);
         for (int i = 0; i < N; i++)
            chk($sformatf("d_valid%0d", i), tl_h_o[i].d_valid, (i == h) ? tl_d_i.d_valid : 1'b0);
         if (tl_d_i.d_valid && dr) begin
            if (h >= 0) begin
               chk("d_data", tl_h_o[h].d_data, sb[0].data);
               chk("d_source", tl_h_o[h].d_source, sb[0].source);
               void'(sb.pop_front());
               cnt--;
            end else exp_err = 1;
         end
         // A channel outcome
         if (eav && tl_d_i.a_ready) begin
            sb.push_back('{w, tl_h_i[w].a_address ^ DKEY, tl_h_i[w].a_source});
            last_gnt = w; pend = 0; cnt++;
         end else if (eav) begin
            pend = 1; pend_host = w; pend_addr = tl_h_i[w].a_address;
         end
         // environment bookkeeping from the real interface signals
         for (int i = 0; i < N; i++) hs_host[i] = tl_h_i[i].a_valid && tl_h_o[i].a_ready;
         dev_dhs = tl_d_i.d_valid && tl_d_o.d_ready;
         if (tl_d_o.a_valid && tl_d_i.a_ready) dev_q.push_back('{tl_d_o.a_address, tl_d_o.a_source});
      end
   end

   // stimulus state
   bit      req_act[N];
   tl_h2d_t req[N];
   bit      d_act = 0, spur = 0, fixed_addr = 0;
   int      host_en = 0, req_rate = 0, ar_rate = 0, dv_rate = 0, dr_rate = 100;

   task automatic step();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         if (req_act[i] && hs_host[i]) req_act[i] = 0;
         if (!req_act[i] && host_en[i] && $urandom_range(99) < req_rate) begin
            req_act[i]           = 1;
            req[i]               = '0;
            req[i].a_valid       = 1'b1;
            req[i].a_opcode      = $urandom_range(1) ? 3'd4 : 3'd0;
            req[i].a_size        = 2'd2;
            req[i].a_source      = 8'($urandom);
            req[i].a_address     = fixed_addr ? 32'h8000_0000 : ($urandom & 32'hFFFF_FFFC);
            req[i].a_mask        = 4'hF;
            req[i].a_data        = $urandom;
         end
         tl_h_i[i]         = req_act[i] ? req[i] : '0;
         tl_h_i[i].d_ready = ($urandom_range(99) < dr_rate);
      end
      if (d_act && dev_dhs) begin void'(dev_q.pop_front()); d_act = 0; end
      if (!d_act && dev_q.size() > 0 && $urandom_range(99) < dv_rate) d_act = 1;
      tl_d_i         = '0;
      tl_d_i.a_ready = ($urandom_range(99) < ar_rate);
      if (d_act) begin
         tl_d_i.d_valid  = 1'b1;
         tl_d_i.d_opcode = 3'd1;
         tl_d_i.d_data   = dev_q[0].addr ^ DKEY;
         tl_d_i.d_source = dev_q[0].source;
      end else if (spur) begin
         tl_d_i.d_valid = 1'b1;
         tl_d_i.d_data  = 32'h0BAD_0BAD;
      end
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic drain();
      int guard = 0;
      host_en = 0; dv_rate = 100; dr_rate = 100; ar_rate = 100;
      while ((dev_q.size() > 0 || d_act) && guard < 300) begin step(); guard++; end
      run(2);
      if (guard >= 300) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: %0d beats still pending, required 0", dev_q.size());
      end
   endtask

   task automatic do_reset(int cycles);
      @(posedge clk); #3;
      rst_ni = 1'b0;
      for (int i = 0; i < N; i++) req_act[i] = 0;
      host_en = 0;
      tl_h_i  = '0;
      repeat (cycles) @(posedge clk);
      #1 rst_ni = 1'b1;
   endtask

   initial begin
      tl_h_i = '0;
      tl_d_i = '0;
      for (int i = 0; i < N; i++) req_act[i] = 0;
      repeat (3) @(posedge clk);
      #1 rst_ni = 1'b1;
      // single host at a fixed address: responses read 0xDEADBEEF on host1
      fixed_addr = 1; host_en = 3'b010;
      req_rate = 100; ar_rate = 100; dv_rate = 100; dr_rate = 100;
      run(20);
      fixed_addr = 0;
      // all hosts saturating: strict rotation
      host_en = 3'b111; run(40);
      // device stalls: lock must hold the presented request
      ar_rate = 30; run(100);
      // no responses: FIFO fills and blocks, then drains
      ar_rate = 100; dv_rate = 0; run(20);
      dv_rate = 100; run(20);
      // host-side D backpressure
      dr_rate = 30; dv_rate = 60; run(150);
      // random mix
      for (int s = 0; s < 20; s++) begin
         req_rate = $urandom_range(20, 100);
         ar_rate  = $urandom_range(20, 100);
         dv_rate  = $urandom_range(20, 100);
         dr_rate  = $urandom_range(20, 100);
         run(75);
      end
      drain();
      // spurious response with nothing outstanding: sticky error
      spur = 1; step(); spur = 0;
      run(5);
      // reset mid-burst, then stale responses arrive as unexpected
      host_en = 3'b111; req_rate = 100; ar_rate = 100; dv_rate = 0; dr_rate = 100;
      run(3);
      do_reset(2);
      drain();
      run(3);
      // final reset clears the sticky error
      do_reset(2);
      run(5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
